core_run_ctrl: RTL and testbench

//  Execution sequencer for the single-cycle RISC-V core. Converts raw run/step/halt buttons into
//  a one-cycle-per-instruction enable (core_en) driving the ProgramCounter enable and RegisterFile

---
 rtl/core_run_ctrl_if.sv | 35 +++
 rtl/core_run_ctrl.sv | 163 ++++++++++++++++
 tb/tb_core_run_ctrl.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/core_run_ctrl_if.sv
// core_run_ctrl_if: control/status bundle between the run controller and its user.
//   master modport: drives buttons, pc and breakpoint; observes core_en/state/count.
//   slave modport : the run controller itself.
// Signals:
//   run_btn, step_btn, halt_btn  raw asynchronous buttons (rising edge = request)
//   pc [31:0]                    address of the next instruction
//   bp_addr [31:0], bp_valid     breakpoint address and arm flag
//   core_en                      one-cycle instruction enable
//   state [1:0]                  00 HALTED, 01 RUN, 10 STEP, 11 BREAK
//   halted_bp                    high while stopped at the breakpoint
//   retired_count [CNT_W-1:0]    number of cycles core_en was high
interface core_run_ctrl_if #(
    parameter int unsigned CNT_W = 32
);
    logic             run_btn;
    logic             step_btn;
    logic             halt_btn;
    logic [31:0]      pc;
    logic [31:0]      bp_addr;
    logic             bp_valid;
    logic             core_en;
    logic [1:0]       state;
    logic             halted_bp;
    logic [CNT_W-1:0] retired_count;

    modport master (
        output run_btn, step_btn, halt_btn, pc, bp_addr, bp_valid,
        input  core_en, state, halted_bp, retired_count
    );

    modport slave (
        input  run_btn, step_btn, halt_btn, pc, bp_addr, bp_valid,
        output core_en, state, halted_bp, retired_count
    );
endinterface

// File: rtl/core_run_ctrl.sv
// core_run_ctrl: execution sequencer for the single-cycle core. Turns run/step/halt buttons
// into a registered one-cycle core_en: free-running at one instruction per TICK_DIV clocks,
// single-step, or halted. Counts retired instructions.
// Optional PC breakpoint, enabled by defining CORE_RUN_CTRL_BREAKPOINT_EN.
// Ports:
//   clk    system clock
//   reset  asynchronous, active-high reset
//   bus    core_run_ctrl_if.slave (buttons, pc, breakpoint in; core_en, state,
//          halted_bp, retired_count out)
module core_run_ctrl #(
    parameter int unsigned TICK_DIV    = 50_000_000,
    parameter int unsigned CNT_W       = 32,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic           clk,
    input  logic           reset,
    core_run_ctrl_if.slave bus
);

    localparam int unsigned TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);

    typedef enum logic [1:0] {
        StHalted = 2'b00,
        StRun    = 2'b01,
        StStep   = 2'b10,
        StBreak  = 2'b11
    } state_e;

    // Button synchronizers: bit 0 run, bit 1 step, bit 2 halt.
    // Reset to all ones so a button held through reset produces no edge.
    logic [2:0] btn_raw;
    logic [2:0] sync_q [SYNC_STAGES];
    logic [2:0] prev_q;
    logic [2:0] pulse;
    logic       run_p, step_p, halt_p;

    assign btn_raw = {bus.halt_btn, bus.step_btn, bus.run_btn};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '1;
            prev_q <= '1;
        end else begin
            sync_q[0] <= btn_raw;
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign pulse  = sync_q[SYNC_STAGES-1] & ~prev_q;
    assign run_p  = pulse[0];
    assign step_p = pulse[1];
    assign halt_p = pulse[2];

    state_e           state_q, state_d;
    logic [TICK_W-1:0] tick_q, tick_d;
    logic             core_en_q, core_en_d;
    logic [CNT_W-1:0] count_q;
    logic             bp_hit;

`ifdef CORE_RUN_CTRL_BREAKPOINT_EN
    // skip lets the instruction sitting on the breakpoint execute once after resuming.
    logic skip_q, skip_d;
    assign bp_hit = bus.bp_valid && (bus.pc == bus.bp_addr) && !skip_q;
`else
    assign bp_hit = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        tick_d    = tick_q;
        core_en_d = 1'b0;
`ifdef CORE_RUN_CTRL_BREAKPOINT_EN
        skip_d    = skip_q;
`endif
        unique case (state_q)
            StHalted: begin
                // halt > run > step; halt here simply swallows the others
                if (!halt_p) begin
                    if (run_p) begin
                        state_d = StRun;
                        tick_d  = '0;
                    end else if (step_p) begin
                        state_d   = StStep;
                        core_en_d = 1'b1;
                    end
                end
            end
            StStep: begin
                state_d = StHalted;
            end
            StRun: begin
                if (halt_p) begin
                    state_d = StHalted;
                    tick_d  = '0;
`ifdef CORE_RUN_CTRL_BREAKPOINT_EN
                    skip_d  = 1'b0;
`endif
                end else if (tick_q == TICK_LAST) begin
                    tick_d = '0;
                    if (bp_hit) begin
                        state_d = StBreak;
                    end else begin
                        core_en_d = 1'b1;
`ifdef CORE_RUN_CTRL_BREAKPOINT_EN
                        skip_d    = 1'b0;
`endif
                    end
                end else begin
                    tick_d = tick_q + 1'b1;
                end
            end
            StBreak: begin
`ifdef CORE_RUN_CTRL_BREAKPOINT_EN
                if (halt_p) begin
                    state_d = StHalted;
                    skip_d  = 1'b0;
                end else if (run_p) begin
                    state_d = StRun;
                    tick_d  = '0;
                    skip_d  = 1'b1;
                end else if (step_p) begin
                    state_d   = StStep;
                    core_en_d = 1'b1;
                end
`else
                state_d = StHalted;
`endif
            end
            default: state_d = StHalted;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= StHalted;
            tick_q    <= '0;
            core_en_q <= 1'b0;
            count_q   <= '0;
        end else begin
            state_q   <= state_d;
            tick_q    <= tick_d;
            core_en_q <= core_en_d;
            count_q   <= count_q + CNT_W'(core_en_q);
        end
    end

`ifdef CORE_RUN_CTRL_BREAKPOINT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) skip_q <= 1'b0;
        else       skip_q <= skip_d;
    end
    assign bus.halted_bp = (state_q == StBreak);
`else
    assign bus.halted_bp = 1'b0;
`endif

    assign bus.core_en       = core_en_q;
    assign bus.state         = state_q;
    assign bus.retired_count = count_q;

endmodule

// File: tb/tb_core_run_ctrl.sv
// tb_core_run_ctrl: scoreboard bench for core_run_ctrl. Stimulus tasks push the expected
// retired_count for every instruction they expect to retire; a monitor pops one entry per
// core_en pulse and checks the count, tick spacing and state/halted_bp consistency.
module tb_core_run_ctrl;
    localparam int unsigned TICK_DIV = 7;
    localparam int unsigned CNT_W    = 8;
    localparam int unsigned SYNC     = 2;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    core_run_ctrl_if #(.CNT_W(CNT_W)) bus ();

    core_run_ctrl #(
        .TICK_DIV   (TICK_DIV),
        .CNT_W      (CNT_W),
        .SYNC_STAGES(SYNC)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int          checks   = 0;
    int          failures = 0;
    int          exp_q[$];
    int          exp_cnt  = 0;
    int          seen     = 0;
    int          pend     = 0;
    bit          pend_valid = 1'b0;
    int          cyc      = 0;
    int          last_en  = -1;
    bit          run_seg  = 1'b0;
    logic [31:0] pc_model = 32'h0;

    assign bus.pc = pc_model;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor; also plays the core: pc advances by 4 per retired instruction.
    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (reset) begin
                pend_valid = 1'b0;
                pc_model   = 32'h0;
                last_en    = -1;
            end else begin
                if (pend_valid) begin
                    chk("retired_count_after_en", bus.retired_count, pend);
                    pend_valid = 1'b0;
                end
                chk("halted_bp_vs_state", bus.halted_bp, bus.state == 2'b11);
                if (bus.core_en) begin
                    chk("core_en_state", (bus.state == 2'b01) || (bus.state == 2'b10), 1);
                    if (exp_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_core_en: got core_en=1 at cycle %0d expected 0",
                                 cyc);
                    end else begin
                        pend       = exp_q.pop_front();
                        pend_valid = 1'b1;
                    end
                    if (run_seg && last_en >= 0) chk("run_tick_gap", cyc - last_en, TICK_DIV);
                    last_en  = cyc;
                    seen++;
                    pc_model = pc_model + 32'd4;
                end
            end
        end
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic push(input int k);
        for (int i = 0; i < k; i++) begin
            exp_cnt = (exp_cnt + 1) % (1 << CNT_W);
            exp_q.push_back(exp_cnt);
        end
    endtask

    task automatic press(input bit r, input bit s, input bit h);
        bus.run_btn  = r;
        bus.step_btn = s;
        bus.halt_btn = h;
        repeat (4) @(negedge clk);
        bus.run_btn  = 1'b0;
        bus.step_btn = 1'b0;
        bus.halt_btn = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic wait_seen(input int target, input int limit);
        int n = 0;
        while (seen < target && n < limit) begin
            @(negedge clk);
            n++;
        end
        chk("retire_wait", seen, target);
    endtask

    task automatic check_idle(input string name);
        chk({name, "_state"}, bus.state, 2'b00);
        chk({name, "_core_en"}, bus.core_en, 0);
        chk({name, "_count"}, bus.retired_count, exp_cnt);
        chk({name, "_queue"}, exp_q.size(), 0);
    endtask

    // Run until k instructions retire, then halt right after the k-th one.
    task automatic run_for(input int k, input bit with_step);
        int target = seen + k;
        push(k);
        last_en = -1;
        run_seg = 1'b1;
        press(1'b1, with_step, 1'b0);
        wait_seen(target, k * TICK_DIV + 40);
        press(1'b0, 1'b0, 1'b1);
        repeat (10) @(negedge clk);
        run_seg = 1'b0;
        check_idle("run_for");
    endtask

    task automatic step_once();
        int target = seen + 1;
        push(1);
        press(1'b0, 1'b1, 1'b0);
        repeat (4) @(negedge clk);
        chk("step_retired", seen, target);
        check_idle("step");
    endtask

`ifdef CORE_RUN_CTRL_BREAKPOINT_EN
    // Arm a breakpoint k instructions ahead and run into it.
    task automatic bp_stop(input int k);
        int target = seen + k;
        int n = 0;
        bus.bp_addr  = pc_model + 32'(4 * k);
        bus.bp_valid = 1'b1;
        push(k);
        last_en = -1;
        run_seg = 1'b1;
        press(1'b1, 1'b0, 1'b0);
        while (bus.state != 2'b11 && n < k * TICK_DIV + 60) begin
            @(negedge clk);
            n++;
        end
        repeat (2 * TICK_DIV) @(negedge clk);
        run_seg = 1'b0;
        chk("bp_state", bus.state, 2'b11);
        chk("bp_halted_bp", bus.halted_bp, 1);
        chk("bp_pc", pc_model, bus.bp_addr);
        chk("bp_retired", seen, target);
        chk("bp_count", bus.retired_count, exp_cnt);
    endtask
`endif

    initial begin
        bus.run_btn  = 1'b0;
        bus.step_btn = 1'b0;
        bus.halt_btn = 1'b0;
        bus.bp_addr  = 32'h0;
        bus.bp_valid = 1'b0;
        repeat (5) @(negedge clk);
        reset = 1'b0;

        // Idle after reset
        repeat (200) @(negedge clk);
        check_idle("reset_idle");

        // Free run, then halt
        run_for(6, 1'b0);

        // Three single steps
        for (int i = 0; i < 3; i++) begin
            step_once();
            repeat (10) @(negedge clk);
        end

        // run+halt together: halt wins
        press(1'b1, 1'b0, 1'b1);
        repeat (20) @(negedge clk);
        check_idle("run_halt_same");

        // run+step together: run wins
        run_for(2, 1'b1);

        // Randomized mix
        for (int i = 0; i < 8; i++) begin
            case ($urandom_range(0, 2))
                0:       step_once();
                1:       run_for(int'($urandom_range(1, 4)), 1'b0);
                default: run_for(int'($urandom_range(1, 3)), 1'b1);
            endcase
            repeat ($urandom_range(2, 12)) @(negedge clk);
        end

`ifdef CORE_RUN_CTRL_BREAKPOINT_EN
        // Stop at breakpoint, resume with run (executes it once), then step off another
        bp_stop(4);
        run_for(3, 1'b0);
        chk("bp_resume_pc", pc_model, bus.bp_addr + 32'd12);
        bp_stop(2);
        step_once();
        chk("bp_step_pc", pc_model, bus.bp_addr + 32'd4);
        bus.bp_valid = 1'b0;
`else
        // Breakpoint inputs have no effect
        bus.bp_addr  = pc_model + 32'd4;
        bus.bp_valid = 1'b1;
        run_for(3, 1'b0);
        bus.bp_valid = 1'b0;
`endif

        // Long run wrapping retired_count
        run_for(250, 1'b0);

        // Step held across reset release: no pulse
        bus.step_btn = 1'b1;
        reset = 1'b1;
        exp_q.delete();
        exp_cnt = 0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (20) @(negedge clk);
        check_idle("held_step_reset");
        bus.step_btn = 1'b0;
        repeat (10) @(negedge clk);
        check_idle("held_step_release");

        // Reset asserted while core_en is high in RUN
        begin
            int n = 0;
            push(1);
            press(1'b1, 1'b0, 1'b0);
            while (!bus.core_en && n < 40) begin
                @(negedge clk);
                n++;
            end
            chk("reset_run_en_seen", bus.core_en, 1);
            #2 reset = 1'b1;
            #1;
            chk("reset_run_core_en", bus.core_en, 0);
            chk("reset_run_state", bus.state, 2'b00);
            chk("reset_run_count", bus.retired_count, 0);
            exp_q.delete();
            exp_cnt = 0;
            repeat (3) @(negedge clk);
            reset = 1'b0;
            repeat (20) @(negedge clk);
            check_idle("after_reset_run");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
